// File: rtl/iir_pkg.sv
// Shared types and helpers for the biquad coefficient bank.
// Coefficients are signed Q2.(COEFF_SIZE-2); unity is 1 << frac bits.
package iir_pkg;

  typedef enum logic [2:0] {
    B0 = 3'd0,
    B1 = 3'd1,
    B2 = 3'd2,
    A1 = 3'd3,
    A2 = 3'd4
  } coeff_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    PEND = 2'd2
  } bank_state_e;

  localparam int DEF_COEFF_SIZE = 16;
  localparam int COEFF_Q_FRAC   = DEF_COEFF_SIZE - 2;

  function automatic logic [63:0] unity(input int coeff_size);
    return 64'd1 << (coeff_size - 2);
  endfunction

endpackage

// File: rtl/iir_coeff_regs.sv
// One coefficient bank: STAGE_CNT x {b0,b1,b2,a1,a2}, single-cycle update, no backpressure.
// Priority per edge: full-bank load, then per-stage unity load, then single write.
module iir_coeff_regs
  import iir_pkg::*;
#(
  parameter int STAGE_CNT  = 8,
  parameter int COEFF_SIZE = 16,
  localparam int SW = (STAGE_CNT > 1) ? $clog2(STAGE_CNT) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_wr_en,
  input  logic [SW-1:0]                        i_wr_stage,
  input  logic [2:0]                           i_wr_sel,
  input  logic [COEFF_SIZE-1:0]                i_wr_data,
  input  logic                                 i_unity_en,
  input  logic [SW-1:0]                        i_unity_stage,
  input  logic                                 i_load_en,
  input  logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] i_load_b0,
  input  logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] i_load_b1,
  input  logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] i_load_b2,
  input  logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] i_load_a1,
  input  logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] i_load_a2,
  output logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] o_b0,
  output logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] o_b1,
  output logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] o_b2,
  output logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] o_a1,
  output logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] o_a2
);

  localparam logic [COEFF_SIZE-1:0] UNITY = COEFF_SIZE'(unity(COEFF_SIZE));

  logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] r_b0, r_b1, r_b2, r_a1, r_a2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b0 <= {STAGE_CNT{UNITY}};
      r_b1 <= '0;
      r_b2 <= '0;
      r_a1 <= '0;
      r_a2 <= '0;
    end else if (i_load_en) begin
      r_b0 <= i_load_b0;
      r_b1 <= i_load_b1;
      r_b2 <= i_load_b2;
      r_a1 <= i_load_a1;
      r_a2 <= i_load_a2;
    end else begin
      for (int s = 0; s < STAGE_CNT; s++) begin
        if (i_unity_en && (i_unity_stage == SW'(s))) begin
          r_b0[s] <= UNITY;
          r_b1[s] <= '0;
          r_b2[s] <= '0;
          r_a1[s] <= '0;
          r_a2[s] <= '0;
        end else if (i_wr_en && (i_wr_stage == SW'(s))) begin
          // Out-of-range selects are filtered upstream; default keeps the bank intact anyway.
          case (coeff_sel_e'(i_wr_sel))
            B0:      r_b0[s] <= i_wr_data;
            B1:      r_b1[s] <= i_wr_data;
            B2:      r_b2[s] <= i_wr_data;
            A1:      r_a1[s] <= i_wr_data;
            A2:      r_a2[s] <= i_wr_data;
            default: ;
          endcase
        end
      end
    end
  end

  assign o_b0 = r_b0;
  assign o_b1 = r_b1;
  assign o_b2 = r_b2;
  assign o_a1 = r_a1;
  assign o_a2 = r_a2;

endmodule

// File: rtl/iir_coeff_bank.sv
// Shadow/active coefficient banks for the biquad cascade; commit lands on the next sample_tick.
// wr_ready drops while INIT (STAGE_CNT cycles) or a commit is pending; all outputs registered.
module iir_coeff_bank
  import iir_pkg::*;
#(
  parameter int STAGE_CNT  = 8,
  parameter int COEFF_SIZE = 16,
  localparam int SW = (STAGE_CNT > 1) ? $clog2(STAGE_CNT) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 wr_valid,
  output logic                                 wr_ready,
  input  logic [SW-1:0]                        wr_stage,
  input  logic [2:0]                           wr_sel,
  input  logic [COEFF_SIZE-1:0]                wr_data,
  output logic                                 wr_err,
  input  logic                                 commit_req,
  input  logic                                 init_req,
  input  logic                                 sample_tick,
  output logic                                 commit_done,
  output logic                                 busy,
  output logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] coeff_b0,
  output logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] coeff_b1,
  output logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] coeff_b2,
  output logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] coeff_a1,
  output logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] coeff_a2
);

  bank_state_e r_state, w_state_nxt;
  logic [SW-1:0] r_cnt;
  logic          r_wr_ready, r_wr_err, r_commit_done, r_busy;

  logic w_wr_acc, w_addr_ok, w_wr_en, w_init_en, w_commit;
  logic [STAGE_CNT-1:0][COEFF_SIZE-1:0] w_sh_b0, w_sh_b1, w_sh_b2, w_sh_a1, w_sh_a2;

  // r_wr_ready is high exactly when the FSM sits in IDLE.
  assign w_wr_acc  = wr_valid & r_wr_ready;
  assign w_addr_ok = (wr_sel <= A2) && ({1'b0, wr_stage} < (SW+1)'(STAGE_CNT));
  assign w_wr_en   = w_wr_acc & w_addr_ok;
  assign w_init_en = (r_state == INIT);
  assign w_commit  = (r_state == PEND) & sample_tick;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (init_req)        w_state_nxt = INIT;
        else if (commit_req) w_state_nxt = PEND;
      end
      INIT:    if (r_cnt == SW'(STAGE_CNT - 1)) w_state_nxt = IDLE;
      PEND:    if (sample_tick) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_wr_ready    <= 1'b1;
      r_wr_err      <= 1'b0;
      r_commit_done <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wr_ready    <= (w_state_nxt == IDLE);
      r_busy        <= (w_state_nxt != IDLE);
      r_wr_err      <= w_wr_acc & ~w_addr_ok;
      r_commit_done <= w_commit;
      if (r_state == IDLE)      r_cnt <= '0;
      else if (r_state == INIT) r_cnt <= r_cnt + SW'(1);
    end
  end

  assign wr_ready    = r_wr_ready;
  assign wr_err      = r_wr_err;
  assign commit_done = r_commit_done;
  assign busy        = r_busy;

  iir_coeff_regs #(.STAGE_CNT(STAGE_CNT), .COEFF_SIZE(COEFF_SIZE)) u_shadow (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_wr_en       (w_wr_en),
    .i_wr_stage    (wr_stage),
    .i_wr_sel      (wr_sel),
    .i_wr_data     (wr_data),
    .i_unity_en    (w_init_en),
    .i_unity_stage (r_cnt),
    .i_load_en     (1'b0),
    .i_load_b0     ('0),
    .i_load_b1     ('0),
    .i_load_b2     ('0),
    .i_load_a1     ('0),
    .i_load_a2     ('0),
    .o_b0          (w_sh_b0),
    .o_b1          (w_sh_b1),
    .o_b2          (w_sh_b2),
    .o_a1          (w_sh_a1),
    .o_a2          (w_sh_a2)
  );

  iir_coeff_regs #(.STAGE_CNT(STAGE_CNT), .COEFF_SIZE(COEFF_SIZE)) u_active (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_wr_en       (1'b0),
    .i_wr_stage    ('0),
    .i_wr_sel      ('0),
    .i_wr_data     ('0),
    .i_unity_en    (1'b0),
    .i_unity_stage ('0),
    .i_load_en     (w_commit),
    .i_load_b0     (w_sh_b0),
    .i_load_b1     (w_sh_b1),
    .i_load_b2     (w_sh_b2),
    .i_load_a1     (w_sh_a1),
    .i_load_a2     (w_sh_a2),
    .o_b0          (coeff_b0),
    .o_b1          (coeff_b1),
    .o_b2          (coeff_b2),
    .o_a1          (coeff_a1),
    .o_a2          (coeff_a2)
  );

endmodule

// File: tb/tb_iir_coeff_bank.sv
// Scoreboard bench for iir_coeff_bank: transaction-level model predicts per-cycle flags and committed banks.
module tb_iir_coeff_bank;

  localparam int SC = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_valid = 1'b0, commit_req = 1'b0, init_req = 1'b0, sample_tick = 1'b0;
  logic [2:0] wr_stage = '0;
  logic [2:0] wr_sel = '0;
  logic [CW-1:0] wr_data = '0;
  logic wr_ready, wr_err, commit_done, busy;
  logic [SC-1:0][CW-1:0] coeff_b0, coeff_b1, coeff_b2, coeff_a1, coeff_a2;

  always #5 clk = ~clk;

  iir_coeff_bank #(.STAGE_CNT(SC), .COEFF_SIZE(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_stage(wr_stage), .wr_sel(wr_sel),
    .wr_data(wr_data), .wr_err(wr_err), .commit_req(commit_req), .init_req(init_req),
    .sample_tick(sample_tick), .commit_done(commit_done), .busy(busy),
    .coeff_b0(coeff_b0), .coeff_b1(coeff_b1), .coeff_b2(coeff_b2),
    .coeff_a1(coeff_a1), .coeff_a2(coeff_a2)
  );

  typedef logic [SC*5-1:0][CW-1:0] bank_t;
  typedef struct packed {logic err; logic done; logic busy; logic ready;} exp_t;

  int n_tests = 0;
  int n_fail  = 0;

  bank_t m_sh, m_ac, mon_ac;
  int    m_init_left, m_init_ptr;
  bit    m_pend;
  exp_t  exp_q[$];
  bank_t bank_q[$];

  function automatic bank_t reset_bank();
    bank_t b = '0;
    for (int s = 0; s < SC; s++) b[s*5] = 16'h4000;
    return b;
  endfunction

  function automatic bank_t dut_bank();
    bank_t b;
    for (int s = 0; s < SC; s++) begin
      b[s*5+0] = coeff_b0[s];
      b[s*5+1] = coeff_b1[s];
      b[s*5+2] = coeff_b2[s];
      b[s*5+3] = coeff_a1[s];
      b[s*5+4] = coeff_a2[s];
    end
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bank(input string name, input bank_t act, input bank_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      for (int k = 0; k < SC*5; k++) begin
        if (act[k] !== exp[k]) begin
          $display("FAIL %s: stage %0d coeff %0d got %h expected %h at %0t",
                   name, k/5, k%5, act[k], exp[k], $time);
          break;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_sh = reset_bank();
    m_ac = reset_bank();
    mon_ac = reset_bank();
    m_init_left = 0;
    m_init_ptr = 0;
    m_pend = 1'b0;
    exp_q.delete();
    bank_q.delete();
  endtask

  // One clock of stimulus; the model predicts what the DUT shows after the coming edge.
  task automatic step(input logic v, input logic [2:0] st, input logic [2:0] sel,
                      input logic [CW-1:0] d, input logic c, input logic i, input logic t);
    exp_t e;
    @(negedge clk);
    wr_valid = v; wr_stage = st; wr_sel = sel; wr_data = d;
    commit_req = c; init_req = i; sample_tick = t;
    e = '0;
    if (m_init_left == 0 && !m_pend) begin
      if (v) begin
        if (sel <= 3'd4) m_sh[st*5 + sel] = d;
        else e.err = 1'b1;
      end
      if (i) begin
        m_init_left = SC;
        m_init_ptr = 0;
      end else if (c) begin
        m_pend = 1'b1;
      end
    end else if (m_init_left > 0) begin
      m_sh[m_init_ptr*5+0] = 16'h4000;
      for (int k = 1; k < 5; k++) m_sh[m_init_ptr*5+k] = '0;
      m_init_ptr++;
      m_init_left--;
    end else if (t) begin
      m_ac = m_sh;
      m_pend = 1'b0;
      e.done = 1'b1;
      bank_q.push_back(m_ac);
    end
    e.busy = (m_init_left > 0) || m_pend;
    e.ready = !e.busy;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, '0, 0, 0, 0);
  endtask

  task automatic check_reset_outs(input string tag);
    check_bank({tag, "_bank"}, dut_bank(), reset_bank());
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(commit_done), 32'd0);
    check({tag, "_err"}, 32'(wr_err), 32'd0);
    check({tag, "_ready"}, 32'(wr_ready), 32'd1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_err", 32'(wr_err), 32'(e.err));
        check("commit_done", 32'(commit_done), 32'(e.done));
        check("busy", 32'(busy), 32'(e.busy));
        check("wr_ready", 32'(wr_ready), 32'(e.ready));
        if (e.done && bank_q.size() > 0) mon_ac = bank_q.pop_front();
        check_bank("active_bank", dut_bank(), mon_ac);
      end
    end
  end

  initial begin : driver
    model_reset();
    #12;
    check_reset_outs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Single write to stage 3 a1, commit, tick five cycles later.
    step(1, 3, 3'd3, 16'hC123, 0, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0);
    idle(4);
    step(0, 0, 0, '0, 0, 0, 1);
    idle(2);

    // Invalid select: error pulse, bank unchanged after commit.
    step(1, 5, 3'd6, 16'h7FFF, 0, 0, 0);
    step(1, 2, 3'd7, 16'h1234, 0, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0);
    step(0, 0, 0, '0, 0, 0, 1);
    idle(2);

    // Fill shadow with non-unity values, re-init, commit.
    for (int s = 0; s < SC; s++)
      for (int k = 0; k < 5; k++)
        step(1, 3'(s), 3'(k), 16'(($urandom & 16'h3FFF) | 16'h0101), 0, 0, 0);
    step(0, 0, 0, '0, 0, 1, 0);
    idle(10);
    step(0, 0, 0, '0, 1, 0, 0);
    idle(1);
    step(0, 0, 0, '0, 0, 0, 1);
    idle(2);

    // init and commit on the same edge: init wins, no commit follows.
    step(1, 1, 3'd1, 16'h5555, 0, 0, 0);
    step(0, 0, 0, '0, 1, 1, 0);
    for (int k = 0; k < 12; k++) step(0, 0, 0, '0, 0, 0, 1);

    // write + commit + tick on one edge; write + init on one edge.
    step(1, 6, 3'd2, 16'h8001, 1, 0, 1);
    step(0, 0, 0, '0, 0, 0, 0);
    step(0, 0, 0, '0, 0, 0, 1);
    step(1, 0, 3'd0, 16'hAAAA, 0, 1, 0);
    idle(9);
    step(0, 0, 0, '0, 1, 0, 1);
    step(0, 0, 0, '0, 0, 0, 1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 1), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           16'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 24) == 0),
           ($urandom_range(0, 4) == 0));
    idle(12);

    // Reset while a commit is pending.
    step(1, 4, 3'd4, 16'h0F0F, 0, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0);
    idle(2);
    @(negedge clk);
    wr_valid = 0; commit_req = 0; init_req = 0; sample_tick = 1;
    rst_n = 1'b0;
    #1;
    check_reset_outs("pend_reset");
    model_reset();
    @(negedge clk);
    sample_tick = 0;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step(0, 0, 0, '0, 0, 0, 1);
    idle(2);

    @(posedge clk);
    #2;
    check("sb_drained", 32'(exp_q.size() + bank_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iir_coeff_bank.md
Name: iir_coeff_bank

Overview:
- Upstream coefficient source for the cascaded biquad filter. Drives that filter's coeff_b0/b1/b2/a1/a2 packed arrays.
- Host writes go into a shadow bank through a valid/ready port.
- A commit request copies shadow to active only on a sample boundary, so the filter never sees a half-updated coefficient set.
- Provides a sequenced re-initialisation of the shadow bank to pass-through (unity) values.

Parameters:
- STAGE_CNT, 8, number of biquad stages served.
- COEFF_SIZE, 16, coefficient width; signed fixed point Q2.(COEFF_SIZE-2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  coefficient write request
- wr_ready  out  1  write accepted when wr_valid & wr_ready at clk edge
- wr_stage  in  $clog2(STAGE_CNT)  target stage index
- wr_sel  in  3  coefficient select: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2, 5-7 invalid
- wr_data  in  COEFF_SIZE  coefficient value
- wr_err  out  1  one-cycle pulse: an accepted write had an invalid address
- commit_req  in  1  request shadow-to-active transfer
- init_req  in  1  request shadow re-initialisation to unity
- sample_tick  in  1  one-cycle strobe marking the filter sample boundary
- commit_done  out  1  one-cycle pulse after the active bank is updated
- busy  out  1  high in INIT or PEND
- coeff_b0, coeff_b1, coeff_b2, coeff_a1, coeff_a2  out  [STAGE_CNT-1:0][COEFF_SIZE-1:0]  active coefficients to the filter

Behaviour:
- Reset (async assert, sync-to-clk deassert usage):
  - Shadow and active banks: b0 = UNITY = 1<<(COEFF_SIZE-2); b1, b2, a1, a2 = 0 for every stage.
  - State = IDLE; wr_err = 0; commit_done = 0; busy = 0; wr_ready = 1 once reset is released.
- All outputs are registered. Active coefficient outputs change only on a commit edge.
- FSM, IDLE:
  - wr_ready = 1.
  - An accepted write updates shadow[wr_stage][wr_sel] at that edge.
  - init_req → INIT; stage counter = 0.
  - Else commit_req → PEND.
  - sample_tick alone has no effect.
- FSM, INIT:
  - wr_ready = 0.
  - Each cycle, shadow[cnt] is set to unity and cnt increments.
  - After cnt = STAGE_CNT-1 is written → IDLE. INIT takes exactly STAGE_CNT cycles.
  - commit_req and init_req are ignored while in INIT.
  - Active bank is untouched.
- FSM, PEND:
  - wr_ready = 0.
  - On the edge where sample_tick = 1, active ← shadow (all stages, all five coefficients) and state → IDLE.
  - commit_done = 1 for the following cycle.
  - commit_req and init_req are ignored in PEND.
- Simultaneous events:
  - wr_valid + commit_req in IDLE at the same edge: the write is accepted and included in the pending commit.
  - init_req + commit_req at the same edge: init wins; commit_req is dropped.
  - init_req + wr_valid in IDLE at the same edge: the write is accepted, then INIT overwrites that stage.
- Invalid address:
  - Applies to wr_sel > 4, or wr_stage ≥ STAGE_CNT when STAGE_CNT is not a power of two.
  - The handshake completes, shadow is unchanged, and wr_err pulses for 1 cycle after acceptance.
- Latency:
  - commit_req edge to active change = number of cycles until the next sample_tick (minimum 1).
  - If sample_tick is asserted in the same cycle as commit_req (in IDLE), it does not commit; the next tick does.
- Reset mid-INIT or mid-PEND: both banks return to reset values; the pending commit is lost; no commit_done is produced.
- wr_data is stored verbatim, with no saturation or sign manipulation.

Decomposition:
- Shared package iir_pkg holds:
  - coeff_sel_e enum (B0, B1, B2, A1, A2).
  - Localparam COEFF_Q_FRAC = COEFF_SIZE-2.
  - Function unity(COEFF_SIZE).
  - bank_state_e enum (IDLE, INIT, PEND).
- One sub-module, iir_coeff_regs:
  - Holds one bank (STAGE_CNT × 5 registers).
  - Has write-enable/address/data ports, a per-stage load-unity port and a full-bank parallel-load port.
  - Instantiated twice: shadow and active.
- The FSM, counter and handshake stay in iir_coeff_bank.

Test Plan:
- Reset with STAGE_CNT=8, COEFF_SIZE=16 → every coeff_b0[k] = 16'h4000, all other coefficients 0, wr_ready = 1, busy = 0.
- Write stage 3 a1 = 16'hC123, then commit_req; sample_tick 5 cycles later → coeff_a1[3] unchanged until the tick edge, then 16'hC123; commit_done pulses once; busy falls with the commit.
- Write with wr_sel = 6, wr_data = 16'h7FFF → wr_err = 1 for one cycle; after commit, all coefficients are unchanged.
- Load non-unity values into all shadow stages, then init_req → busy for exactly 8 cycles with wr_ready = 0; a subsequent commit restores unity on all 8 stages.
- Issue init_req and commit_req on the same edge → INIT runs, no PEND entered, no commit_done, active bank unchanged.
- Assert rst_n low while in PEND → outputs return to reset values immediately (async); a later sample_tick produces no commit_done.
